div_controller: RTL and testbench
=================================

Name: div_controller

Overview:
- Sequences the multi-cycle 32-bit divider for the M-extension DIV/DIVU/REM/REMU ops on behalf of the execute stage.
- Handles divide-by-zero and signed overflow itself, without starting the divider.
- Holds divider operands stable for the whole operation.
- Discards in-flight results on pipeline flush and returns one tagged result per accepted request.

Parameters:
- TAG_W, 5, width of the destination-register tag carried with each request.
- RESET_DRAIN, 40, cycles after reset during which no request is accepted, so that a divider left mid-operation can return to idle.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents an op
- req_ready  out  1  controller can accept; high only in IDLE with the drain counter at 0
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- req_tag  in  TAG_W  destination tag
- flush  in  1  kill the pending op
- busy  out  1  high in any state other than IDLE; pipeline stall source
- resp_valid  out  1  one-cycle result strobe
- resp_data  out  32  quotient or remainder
- resp_tag  out  TAG_W  tag of the accepted request
- div_start  out  1  divider start pulse
- div_dividend  out  32  registered dividend to the divider
- div_divisor  out  32  registered divisor to the divider
- div_is_unsigned  out  1  registered signedness
- div_done  in  1  divider finished
- div_val  in  32  divider quotient
- div_rem  in  32  divider remainder

Behaviour:
- Reset:
  - State goes to IDLE; the drain counter loads RESET_DRAIN.
  - resp_valid=0, resp_data=0, resp_tag=0, div_start=0, operand registers=0, busy=0.
  - req_ready stays 0 until the drain counter reaches 0; it decrements once per cycle.
- Accept: req_valid && req_ready at a rising edge captures op, operands and tag.
  - DIV and REM set div_is_unsigned=0; DIVU and REMU set it to 1.
- State machine: IDLE, ISSUE, WAIT, RESP, DRAIN.
  - IDLE -> ISSUE on a normal accept.
  - IDLE -> RESP on a special-case accept. The result is computed at accept; resp_valid is high the next cycle.
  - ISSUE: div_start=1 for exactly one cycle, then -> WAIT.
  - WAIT: on div_done, latch div_val for DIV/DIVU or div_rem for REM/REMU, then -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE. req_ready stays 0 in this cycle, so there is no back-to-back accept.
- Special cases, checked at accept:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = dividend.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Operand stability: div_dividend, div_divisor and div_is_unsigned must not change from ISSUE until div_done is sampled. The divider's outputs depend combinationally on them.
- Latency:
  - Controller cost is accept + ISSUE + RESP around the divider latency.
  - With the current divider, div_done rises 35 cycles after the div_start cycle, so resp_valid comes 37 cycles after accept.
  - Special case: resp_valid 1 cycle after accept.
- Flush:
  - In ISSUE or WAIT: -> DRAIN. DRAIN waits for div_done with no response, then -> IDLE.
  - In RESP: suppresses resp_valid and -> IDLE.
  - In IDLE: no effect. flush has priority over an accept in the same cycle.
- Simultaneous events: div_done in the same cycle as flush while in WAIT -> result discarded, -> IDLE directly.
- Reset mid-operation: the divider has no reset, so the RESET_DRAIN window guarantees it is idle before the next div_start. A div_done seen during the window is ignored.
- div_start is never asserted outside ISSUE.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- Defined:
  - Keep the last divider-produced quotient and remainder plus operands and signedness, with a valid bit.
  - An accept whose rs1, rs2 and signedness match a valid entry goes IDLE -> RESP with the cached value (1-cycle latency), e.g. DIV followed by REM.
  - Valid is cleared on reset, on flush-discarded results and on DRAIN. Special-case results are not cached.
- Undefined: no cache storage; every non-special op goes through ISSUE/WAIT.

Decomposition:
- Shared package: op encoding constants (DIV/DIVU/REM/REMU), state encoding, and constants DIV_ZERO_QUO=0xFFFFFFFF, INT_MIN=0x80000000.
- Natural sub-module: div_special_case, a combinational detector producing special-case hit plus quotient/remainder from op, rs1 and rs2.

Test Plan:
- Post-reset: req_ready=0 for 40 cycles. DIVU 100/7 accepted at cycle T -> resp_valid at T+37 with 14; resp_tag echoes the request tag.
- REM -7/2 -> resp_data 0xFFFFFFFF (-1). DIV -7/2 -> 0xFFFFFFFD (-3). div_dividend held constant from ISSUE to div_done.
- DIV 5/0 -> resp 0xFFFFFFFF, 1-cycle latency, div_start never pulses. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- Flush 10 cycles after issue -> no resp_valid, busy stays high until div_done, then req_ready rises; the next DIVU 9/3 returns 3.
- Reset asserted mid-WAIT, new op offered at the first ready cycle -> correct result; div_start never overlaps the old divide.
- With DIV_RESULT_CACHE_EN: DIV 100/7 then REM 100/7 -> second resp 2, 1 cycle after accept, no div_start.

Source files
------------

// File: rtl/div_controller_pkg.sv
// div_controller_pkg: shared op encodings, FSM states and special-case constants
// for the M-extension divide sequencer.
package div_controller_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE      = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    // REM/REMU return the remainder; DIV/DIVU return the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

    // DIVU/REMU are the unsigned forms.
    function automatic logic op_is_unsigned(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/div_controller_special_case.sv
// div_special_case: combinational detector for divide-by-zero and signed
// overflow; yields the architectural result without involving the divider.
module div_special_case
    import div_controller_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        hit,
    output logic [31:0] result
);

    logic [31:0] quo;
    logic [31:0] rem;

    // Detect the two cases the divider is never asked to handle.
    always_comb begin
        hit = 1'b0;
        quo = '0;
        rem = '0;
        if (rs2 == '0) begin
            hit = 1'b1;
            quo = DIV_ZERO_QUO;
            rem = rs1;
        end else if (!op_is_unsigned(op) && rs1 == INT_MIN && rs2 == NEG_ONE) begin
            hit = 1'b1;
            quo = INT_MIN;
            rem = '0;
        end
        result = op_is_rem(op) ? rem : quo;
    end

endmodule

// File: rtl/div_controller.sv
// div_controller: sequences the multi-cycle divider for DIV/DIVU/REM/REMU,
// resolves special cases locally, holds operands stable and handles flush.
// Optional result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_controller
    import div_controller_pkg::*;
#(
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned RESET_DRAIN = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             busy,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             div_start,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    output logic             div_is_unsigned,
    input  logic             div_done,
    input  logic [31:0]      div_val,
    input  logic [31:0]      div_rem
);

    localparam int unsigned CNT_W = $clog2(RESET_DRAIN + 2);

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   drain_q,    drain_d;
    logic [1:0]         op_q,       op_d;
    logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [31:0]        dividend_q, dividend_d;
    logic [31:0]        divisor_q,  divisor_d;
    logic               uns_q,      uns_d;

    logic               accept;
    logic               sc_hit;
    logic [31:0]        sc_result;

`ifdef DIV_RESULT_CACHE_EN
    logic               cache_valid_q, cache_valid_d;
    logic [31:0]        cache_rs1_q,   cache_rs1_d;
    logic [31:0]        cache_rs2_q,   cache_rs2_d;
    logic               cache_uns_q,   cache_uns_d;
    logic [31:0]        cache_quo_q,   cache_quo_d;
    logic [31:0]        cache_rem_q,   cache_rem_d;
    logic               cache_hit;
`endif

    div_special_case u_special (
        .op     (req_op),
        .rs1    (req_rs1),
        .rs2    (req_rs2),
        .hit    (sc_hit),
        .result (sc_result)
    );

    assign req_ready       = (state_q == ST_IDLE) && (drain_q == '0);
    assign busy            = (state_q != ST_IDLE);
    // Flush in RESP kills the strobe in the same cycle.
    assign resp_valid      = (state_q == ST_RESP) && !flush;
    assign resp_data       = resp_data_q;
    assign resp_tag        = resp_tag_q;
    assign div_start       = (state_q == ST_ISSUE);
    assign div_dividend    = dividend_q;
    assign div_divisor     = divisor_q;
    assign div_is_unsigned = uns_q;

    // Flush wins over a same-cycle accept.
    assign accept = req_valid && req_ready && !flush;

`ifdef DIV_RESULT_CACHE_EN
    // Match on operands and signedness; quotient and remainder share an entry.
    assign cache_hit = cache_valid_q && (cache_rs1_q == req_rs1) && (cache_rs2_q == req_rs2)
                     && (cache_uns_q == op_is_unsigned(req_op));
`endif

    // Next-state, operand capture and result selection.
    always_comb begin
        state_d     = state_q;
        drain_d     = (drain_q != '0) ? drain_q - CNT_W'(1) : drain_q;
        op_d        = op_q;
        resp_tag_d  = resp_tag_q;
        resp_data_d = resp_data_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        uns_d       = uns_q;
`ifdef DIV_RESULT_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_rs1_d   = cache_rs1_q;
        cache_rs2_d   = cache_rs2_q;
        cache_uns_d   = cache_uns_q;
        cache_quo_d   = cache_quo_q;
        cache_rem_d   = cache_rem_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d       = req_op;
                    resp_tag_d = req_tag;
                    dividend_d = req_rs1;
                    divisor_d  = req_rs2;
                    uns_d      = op_is_unsigned(req_op);
                    if (sc_hit) begin
                        resp_data_d = sc_result;
                        state_d     = ST_RESP;
`ifdef DIV_RESULT_CACHE_EN
                    end else if (cache_hit) begin
                        resp_data_d = op_is_rem(req_op) ? cache_rem_q : cache_quo_q;
                        state_d     = ST_RESP;
`endif
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // The start pulse is already out, so a flush must still drain it.
                state_d = flush ? ST_DRAIN : ST_WAIT;
`ifdef DIV_RESULT_CACHE_EN
                if (flush) cache_valid_d = 1'b0;
`endif
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = div_done ? ST_IDLE : ST_DRAIN;
`ifdef DIV_RESULT_CACHE_EN
                    cache_valid_d = 1'b0;
`endif
                end else if (div_done) begin
                    resp_data_d = op_is_rem(op_q) ? div_rem : div_val;
                    state_d     = ST_RESP;
`ifdef DIV_RESULT_CACHE_EN
                    cache_valid_d = 1'b1;
                    cache_rs1_d   = dividend_q;
                    cache_rs2_d   = divisor_q;
                    cache_uns_d   = uns_q;
                    cache_quo_d   = div_val;
                    cache_rem_d   = div_rem;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef DIV_RESULT_CACHE_EN
                if (flush) cache_valid_d = 1'b0;
`endif
            end
            ST_DRAIN: begin
`ifdef DIV_RESULT_CACHE_EN
                cache_valid_d = 1'b0;
`endif
                if (div_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            drain_q     <= CNT_W'(RESET_DRAIN);
            op_q        <= '0;
            resp_tag_q  <= '0;
            resp_data_q <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            uns_q       <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_uns_q   <= 1'b0;
            cache_quo_q   <= '0;
            cache_rem_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            op_q        <= op_d;
            resp_tag_q  <= resp_tag_d;
            resp_data_q <= resp_data_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            uns_q       <= uns_d;
`ifdef DIV_RESULT_CACHE_EN
            cache_valid_q <= cache_valid_d;
            cache_rs1_q   <= cache_rs1_d;
            cache_rs2_q   <= cache_rs2_d;
            cache_uns_q   <= cache_uns_d;
            cache_quo_q   <= cache_quo_d;
            cache_rem_q   <= cache_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_controller.sv
// tb_div_controller: scoreboard bench for div_controller with a 35-cycle
// behavioural divider. Build with DIV_RESULT_CACHE_EN to cover the cache.
module tb_div_controller;
    import div_controller_pkg::*;

    localparam int TAG_W = 5;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [31:0]      req_rs1 = '0;
    logic [31:0]      req_rs2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0;
    logic             busy;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             div_start;
    logic [31:0]      div_dividend;
    logic [31:0]      div_divisor;
    logic             div_is_unsigned;
    logic             div_done;
    logic [31:0]      div_val;
    logic [31:0]      div_rem;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_starts = 0;
    int   done_cyc = -1;
    int   cyc      = 0;

    div_controller #(.TAG_W(TAG_W), .RESET_DRAIN(40)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .req_tag         (req_tag),
        .flush           (flush),
        .busy            (busy),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_tag        (resp_tag),
        .div_start       (div_start),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_is_unsigned (div_is_unsigned),
        .div_done        (div_done),
        .div_val         (div_val),
        .div_rem         (div_rem)
    );

    always #5 clk = ~clk;

    // Behavioural divider: no reset, done 35 cycles after the start cycle,
    // outputs combinational on the operand registers.
    int          div_cnt = 0;
    logic [31:0] st_a = '0;
    logic [31:0] st_b = '0;
    logic        st_u = 1'b0;
    bit          aborted = 1'b0;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (u) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
        return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && div_cnt != 0) aborted <= 1'b1;
        if (div_cnt != 0) div_cnt <= div_cnt - 1;
        else if (div_start) begin
            div_cnt <= 35;
            st_a    <= div_dividend;
            st_b    <= div_divisor;
            st_u    <= div_is_unsigned;
            aborted <= 1'b0;
        end
    end

    assign div_done = (div_cnt == 1);
    assign {div_val, div_rem} = ref_div(div_dividend, div_divisor, div_is_unsigned);

    // Always-on checker: scoreboard pops, start overlap, operand stability.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL resp_unexpected: got data=%h tag=%0d, required no response", resp_data, resp_tag);
                end else begin
                    e = sb.pop_front();
                    if (resp_data !== e.data || resp_tag !== e.tag)
                        $display("FAIL resp_data: got data=%h tag=%0d, required data=%h tag=%0d",
                                 resp_data, resp_tag, e.data, e.tag);
                    else n_pass++;
                end
            end
            if (div_start) begin
                n_starts++;
                n_checks++;
                if (div_cnt != 0) $display("FAIL start_overlap: div_start while divider busy (cnt=%0d), required idle", div_cnt);
                else n_pass++;
            end
            if (div_done) begin
                done_cyc = cyc;
                if (!aborted) begin
                    n_checks++;
                    if (div_dividend !== st_a || div_divisor !== st_b || div_is_unsigned !== st_u)
                        $display("FAIL operand_stable: got %h/%h u=%b, required %h/%h u=%b",
                                 div_dividend, div_divisor, div_is_unsigned, st_a, st_b, st_u);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic submit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input bit push, input logic [31:0] exp,
                          output int acc);
        exp_t e;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready && !reset) begin
                acc = cyc;
                break;
            end
        end
        if (acc >= 0) begin
            req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag; req_valid = 1'b1;
            if (push) begin
                e.data = exp; e.tag = tag;
                sb.push_back(e);
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_resp(output int rc);
        rc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                rc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int r;
        repeat (3) @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || resp_data !== '0 || resp_tag !== '0 || div_start !== 1'b0)
            $display("FAIL reset_resp: got v=%b d=%h t=%0d s=%b, required all 0", resp_valid, resp_data, resp_tag, div_start);
        else n_pass++;
        n_checks++;
        if (div_dividend !== '0 || div_divisor !== '0 || div_is_unsigned !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL reset_regs: got %h/%h u=%b busy=%b ready=%b, required 0", div_dividend, div_divisor,
                     div_is_unsigned, busy, req_ready);
        else n_pass++;
        reset = 1'b0;
        r = cyc;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        n_checks++;
        if (cyc - r !== 40) $display("FAIL reset_drain: ready after %0d cycles, required 40", cyc - r);
        else n_pass++;
    endtask

    task automatic test_divu();
        int acc, rc;
        submit(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b1, 32'd14, acc);
        wait_resp(rc);
        n_checks++;
        if (acc < 0 || rc < 0 || rc - acc != 37) $display("FAIL divu_latency: got %0d, required 37", rc - acc);
        else n_pass++;
    endtask

    task automatic test_signed();
        int acc, rc;
        submit(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFF, acc);
        wait_resp(rc);
        n_checks++;
        if (acc < 0 || rc < 0 || rc - acc != 37) $display("FAIL rem_latency: got %0d, required 37", rc - acc);
        else n_pass++;
        submit(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 32'hFFFF_FFFD, acc);
        wait_resp(rc);
        n_checks++;
        if (acc < 0 || rc < 0 || rc - acc != (CACHE ? 1 : 37))
            $display("FAIL div_latency: got %0d, required %0d", rc - acc, CACHE ? 1 : 37);
        else n_pass++;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic test_special();
        vec_t v[4];
        int   acc, rc, s0;
        v[0] = '{OP_DIV,  32'd5,        32'd0,        32'hFFFF_FFFF};
        v[1] = '{OP_REMU, 32'd5,        32'd0,        32'd5};
        v[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[3] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        s0 = n_starts;
        for (int i = 0; i < 4; i++) begin
            submit(v[i].op, v[i].a, v[i].b, 5'(10 + i), 1'b1, v[i].exp, acc);
            wait_resp(rc);
            n_checks++;
            if (acc < 0 || rc < 0 || rc - acc != 1) $display("FAIL special_latency[%0d]: got %0d, required 1", i, rc - acc);
            else n_pass++;
        end
        n_checks++;
        if (n_starts != s0) $display("FAIL special_no_start: got %0d starts, required 0", n_starts - s0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc, rc;
        exp_t e;
        submit(OP_DIVU, 32'd8, 32'd0, 5'd20, 1'b1, 32'hFFFF_FFFF, acc);
        req_op = OP_REMU; req_rs1 = 32'd8; req_rs2 = 32'd0; req_tag = 5'd21; req_valid = 1'b1;
        e.data = 32'd8; e.tag = 5'd21;
        sb.push_back(e);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b1)
            $display("FAIL b2b_resp_cycle: got ready=%b resp_valid=%b, required 0/1", req_ready, resp_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL b2b_ready: got %b, required 1", req_ready);
        else n_pass++;
        acc = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(rc);
        n_checks++;
        if (rc - acc != 1) $display("FAIL b2b_latency: got %0d, required 1", rc - acc);
        else n_pass++;
    endtask

    task automatic test_flush_idle_priority();
        int acc;
        flush = 1'b1;
        submit(OP_DIVU, 32'd1, 32'd1, 5'd22, 1'b0, 32'd0, acc);
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL flush_idle: got busy=%b ready=%b, required 0/1", busy, req_ready);
        else n_pass++;
    endtask

    task automatic test_flush_resp();
        int acc;
        submit(OP_DIVU, 32'd8, 32'd0, 5'd23, 1'b0, 32'd0, acc);
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL flush_resp: got resp_valid=%b busy=%b, required 0/1", resp_valid, busy);
        else n_pass++;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL flush_resp_idle: got busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_flush_wait();
        int acc, rc, rdy;
        bit busy_ok;
        submit(OP_DIVU, 32'd1000, 32'd3, 5'd24, 1'b0, 32'd0, acc);
        for (int i = 0; i < 10 && !div_start; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        busy_ok = 1'b1;
        rdy = -1;
        for (int i = 0; i < 60; i++) begin
            if (req_ready) begin
                rdy = cyc;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!busy_ok) $display("FAIL flush_busy: busy dropped before div_done, required high");
        else n_pass++;
        n_checks++;
        if (rdy < 0 || rdy != done_cyc + 1) $display("FAIL flush_ready: ready at %0d, required %0d", rdy, done_cyc + 1);
        else n_pass++;
        submit(OP_DIVU, 32'd9, 32'd3, 5'd25, 1'b1, 32'd3, acc);
        wait_resp(rc);
        n_checks++;
        if (acc < 0 || rc < 0 || rc - acc != 37) $display("FAIL after_flush_latency: got %0d, required 37", rc - acc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acc, rc, r;
        submit(OP_DIVU, 32'd50, 32'd5, 5'd26, 1'b0, 32'd0, acc);
        for (int i = 0; i < 10 && !div_start; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r = cyc;
        submit(OP_DIVU, 32'd77, 32'd7, 5'd27, 1'b1, 32'd11, acc);
        n_checks++;
        if (acc - r != 40) $display("FAIL reset_mid_accept: accepted %0d cycles after reset, required 40", acc - r);
        else n_pass++;
        wait_resp(rc);
        n_checks++;
        if (acc < 0 || rc < 0 || rc - acc != 37) $display("FAIL reset_mid_latency: got %0d, required 37", rc - acc);
        else n_pass++;
    endtask

`ifdef DIV_RESULT_CACHE_EN
    task automatic test_cache();
        int acc, rc, s0;
        submit(OP_DIV, 32'd100, 32'd7, 5'd28, 1'b1, 32'd14, acc);
        wait_resp(rc);
        s0 = n_starts;
        submit(OP_REM, 32'd100, 32'd7, 5'd29, 1'b1, 32'd2, acc);
        wait_resp(rc);
        n_checks++;
        if (acc < 0 || rc < 0 || rc - acc != 1) $display("FAIL cache_latency: got %0d, required 1", rc - acc);
        else n_pass++;
        n_checks++;
        if (n_starts != s0) $display("FAIL cache_no_start: got %0d starts, required 0", n_starts - s0);
        else n_pass++;
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_divu();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush_idle_priority();
        test_flush_resp();
        test_flush_wait();
        test_reset_mid();
`ifdef DIV_RESULT_CACHE_EN
        test_cache();
`endif
        repeat (5) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d responses missing, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
